vx_stream_serializer: RTL



---
 rtl/vx_stream_serializer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vx_stream_serializer.sv
// vx_stream_serializer
// Splits one wide input word into NUM_BEATS narrow output beats, LSB beat
// first, with a valid/ready handshake on each side. At most one word is held.
// The next word may be accepted in the same cycle as the last beat of the
// current word handshakes, so consecutive words leave no idle cycle between
// them.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   valid_in   input word valid
//   ready_in   input word can be accepted this cycle (combinational from ready_out)
//   data_in    input word; beat k is data_in[k*OUTW +: OUTW]
//   len_in     number of beats to emit, minus 1
//   valid_out  output beat valid
//   ready_out  downstream accepts the current beat
//   data_out   current beat (registered)
//   idx_out    index of the current beat within its word (registered)
//   last_out   current beat is the final beat of its word (registered)
module vx_stream_serializer #(
  parameter  int DATAW     = 32,
  parameter  int OUTW      = 8,
  localparam int NUM_BEATS = DATAW / OUTW,
  localparam int LENW      = (NUM_BEATS > 2) ? $clog2(NUM_BEATS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  input  logic [LENW-1:0]  len_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [OUTW-1:0]  data_out,
  output logic [LENW-1:0]  idx_out,
  output logic             last_out
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [LENW-1:0] MAX_LEN = LENW'(NUM_BEATS - 1);

  state_t           state_q, state_d;
  logic [DATAW-1:0] held_q, held_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [LENW-1:0]  cnt_q, cnt_d;
  logic [OUTW-1:0]  data_q, data_d;
  logic             last_q, last_d;

  logic [LENW-1:0]  len_clamped;
  logic [OUTW-1:0]  held_beats [NUM_BEATS];
  logic             busy;
  logic             at_last;
  logic             fire_in;
  logic             fire_out;

  // The clamp is only reachable when NUM_BEATS is not a power of two;
  // otherwise every len_in value already names a real beat.
  generate
    if ((1 << LENW) == NUM_BEATS) begin : g_no_clamp
      assign len_clamped = len_in;
    end else begin : g_clamp
      assign len_clamped = (len_in > MAX_LEN) ? MAX_LEN : len_in;
    end
  endgenerate

  // Beat view of the word that will be held after this edge, so the
  // registered data_out can be loaded with the beat that follows.
  generate
    for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_beats
      assign held_beats[gi] = held_d[gi*OUTW +: OUTW];
    end
  endgenerate

  assign busy     = (state_q == BUSY);
  assign at_last  = busy && (cnt_q == len_q);
  assign fire_out = busy && ready_out;
  // Accept a new word when empty, or when the final beat leaves this cycle.
  assign ready_in = !busy || (at_last && ready_out);
  assign fire_in  = valid_in && ready_in;

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    if (fire_in) begin
      // Covers both the IDLE load and the reload on the last beat handshake.
      state_d = BUSY;
      held_d  = data_in;
      len_d   = len_clamped;
      cnt_d   = '0;
    end else if (fire_out) begin
      if (cnt_q == len_q) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    data_d = held_beats[cnt_d];
    last_d = (state_d == BUSY) && (cnt_d == len_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      held_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_out = busy;
  assign data_out  = data_q;
  assign idx_out   = cnt_q;
  assign last_out  = last_q;

endmodule
